// File: rtl/shift_seq8_pkg.sv
// shift_seq8_pkg: shared widths, op encodings and FSM states
package shift_seq8_pkg;
  localparam int DATA_W = 8;
  localparam int AMT_W = 3;
  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step8.sv
// shift_step8: single-bit shift or rotate of an 8-bit value
module shift_step8
  import shift_seq8_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_data
);
  // one-step result for the selected op
  always_comb
    o_data = (i_op == OP_LSL) ? {i_data[6:0], 1'b0} :
             (i_op == OP_LSR) ? {1'b0, i_data[7:1]} :
             (i_op == OP_ASR) ? {i_data[7], i_data[7:1]} :
             (i_op == OP_ROL) ? {i_data[6:0], i_data[7]} :
                                {i_data[0], i_data[7:1]};
endmodule

// File: rtl/shift_seq8.sv
// shift_seq8: multi-cycle shifter applying one bit of shift per clock
module shift_seq8
  import shift_seq8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [AMT_W-1:0]  amount,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              err
);
  state_t r_state, w_state_nxt;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0] r_op;
  logic [DATA_W-1:0] r_data, w_step;
  logic r_err, w_accept, w_illegal;
  shift_step8 u_step (.i_data(r_data), .i_op(r_op), .o_data(w_step));
  // next state; start is only honoured outside SHIFT
  always_comb begin
    w_state_nxt = IDLE;
    w_accept = 1'b0;
    w_illegal = 1'b0;
    if (r_state == SHIFT) w_state_nxt = (r_cnt == AMT_W'(1)) ? DONE : SHIFT;
    else if (start) begin
      w_accept = (op <= OP_ROR);
      w_illegal = !w_accept;
      w_state_nxt = !w_accept ? IDLE : (amount != '0) ? SHIFT : DONE;
    end
  end
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_state_nxt;
  // working register, counter, latched op and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt <= '0;
      r_op <= OP_LSL;
      r_err <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (w_accept) begin
        r_data <= din;
        r_cnt <= amount;
        r_op <= op;
      end else if (r_state == SHIFT) begin
        r_data <= w_step;
        r_cnt <= r_cnt - AMT_W'(1);
      end
    end
  end
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign dout = r_data;
  assign err = r_err;
endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: directed checks of the sequential shifter
module tb_shift_seq8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] op = '0, amount = '0;
  logic [7:0] din = '0, dout;
  logic busy, done, err;
  int checks = 0, errors = 0;
  shift_seq8 dut (.clk(clk), .reset(reset), .start(start), .op(op), .amount(amount),
                  .din(din), .busy(busy), .done(done), .dout(dout), .err(err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [2:0] o, input logic [7:0] d, input logic [2:0] a);
    start = 1'b1; op = o; din = d; amount = a;
    tick;
    start = 1'b0; op = 3'b110; din = 8'h33; amount = 3'd7;
  endtask
  task automatic finish_op(input string tag, input int lat, input logic [7:0] e);
    int n = 0, nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy_cnt"}, nb, lat);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_err_at_done"}, err, 0);
    chk({tag, "_dout"}, dout, e);
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [7:0] d, input logic [2:0] a, input logic [7:0] e);
    go(o, d, a);
    finish_op(tag, a, e);
    tick;
    chk({tag, "_done_1cyc"}, done, 0);
  endtask
  initial begin
    int nd;
    tick; tick;
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dout", dout, 8'h00);
    run("lsl", 3'b000, 8'h81, 3'd3, 8'h08);
    run("asr", 3'b010, 8'h90, 3'd2, 8'hE4);
    run("ror", 3'b100, 8'h01, 3'd7, 8'h02);
    run("rol", 3'b011, 8'h80, 3'd1, 8'h01);
    run("amt0", 3'b001, 8'h5A, 3'd0, 8'h5A);
    go(3'b001, 8'hF0, 3'd4);
    tick;
    start = 1'b1; op = 3'b000; din = 8'hFF; amount = 3'd1;
    tick;
    start = 1'b0;
    finish_op("ignore", 2, 8'h0F);
    go(3'b011, 8'h80, 3'd1);
    chk("b2b_busy", busy, 1);
    tick;
    chk("b2b_done", done, 1);
    chk("b2b_dout", dout, 8'h01);
    tick;
    go(3'b000, 8'h01, 3'd5);
    tick;
    reset = 1'b1; start = 1'b1; op = 3'b000; din = 8'hAA; amount = 3'd0;
    tick;
    reset = 1'b0; start = 1'b0;
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) nd++;
      tick;
    end
    chk("midrst_no_done", nd, 0);
    run("load5a", 3'b000, 8'h5A, 3'd0, 8'h5A);
    start = 1'b1; op = 3'b111; din = 8'hC3; amount = 3'd2;
    tick;
    start = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_done", done, 0);
    chk("ill_dout", dout, 8'h5A);
    tick;
    chk("ill_err_1cyc", err, 0);
    chk("ill_dout_hold", dout, 8'h5A);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
